clock_gen_rst_seq: RTL and testbench

- Parametrised reset sequencer that sits behind a board PLL wrapper in the PLL output clock domain.
- Synchronises the PLL `locked` flag and holds reset until lock has been stable for a programmable time.
- Releases NUM_RST reset domains in staggered order.
- Re-sequences on loss of lock, pulses the PLL `areset` when lock does not arrive within a timeout, and counts lock-loss events.

---
 rtl/clock_gen_rst_seq_if.sv | 27 ++
 rtl/clock_gen_rst_seq.sv | 151 +++++++++++++++
 tb/tb_clock_gen_rst_seq.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_gen_rst_seq_if.sv
// Status/control bundle between the reset sequencer and the PLL wrapper / reset consumers.
// The master side is the sequencer: it samples the lock flag and drives all reset outputs.
interface clock_gen_rst_seq_if #(
  parameter int NUM_RST = 3
);
  logic               i_locked;
  logic               o_pll_areset;
  logic [NUM_RST-1:0] o_rst;
  logic               o_ready;
  logic [7:0]         o_relock_cnt;

  modport master (
    input  i_locked,
    output o_pll_areset,
    output o_rst,
    output o_ready,
    output o_relock_cnt
  );

  modport slave (
    output i_locked,
    input  o_pll_areset,
    input  o_rst,
    input  o_ready,
    input  o_relock_cnt
  );
endinterface

// File: rtl/clock_gen_rst_seq.sv
// Reset sequencer in the PLL output clock domain: waits for stable lock, releases
// NUM_RST reset domains in ascending staggered order and re-sequences on lock loss.
module clock_gen_rst_seq #(
  parameter int HOLD_CYCLES  = 16,
  parameter int NUM_RST      = 3,
  parameter int STAGE_GAP    = 4,
  parameter int AR_PULSE     = 8,
  parameter int LOCK_TIMEOUT = 65536
) (
  input logic                  i_clk,
  input logic                  i_rst,
  clock_gen_rst_seq_if.master  bus
);

  localparam int M1      = (LOCK_TIMEOUT > AR_PULSE) ? LOCK_TIMEOUT : AR_PULSE;
  localparam int M2      = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_PULSE);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sync_q, sync_d;
  logic               areset_q, areset_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic [NUM_RST-1:0] rst_shift;
  logic               ready_q, ready_d;
  logic [7:0]         relock_q, relock_d;
  logic               locked_s;

  assign locked_s  = sync_q[1];
  // Resets clear from bit 0 upwards, so releasing the next stage is a left shift.
  assign rst_shift = rst_q << 1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= RESET_PLL;
      cnt_q    <= '0;
      sync_q   <= '0;
      areset_q <= 1'b1;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      areset_q <= areset_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      relock_q <= relock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sync_d   = {sync_q[0], bus.i_locked};
    areset_d = 1'b0;
    rst_d    = rst_q;
    ready_d  = ready_q;
    relock_d = relock_q;

    unique case (state_q)
      RESET_PLL: begin
        // Entry from a timeout preloads 1 so that pulse lasts exactly AR_PULSE cycles.
        if (cnt_q == AR_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          areset_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d  = RESET_PLL;
          cnt_d    = CNT_W'(1);
          areset_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          rst_d   = rst_shift;
          state_d = (rst_shift == '0) ? RUN : RELEASE;
          ready_d = (rst_shift == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          rst_d   = rst_shift;
          state_d = (rst_shift == '0) ? RUN : RELEASE;
          ready_d = (rst_shift == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
      default: begin
        state_d  = RESET_PLL;
        cnt_d    = '0;
        areset_d = 1'b1;
        rst_d    = '1;
        ready_d  = 1'b0;
      end
    endcase
  end

  assign bus.o_pll_areset = areset_q;
  assign bus.o_rst        = rst_q;
  assign bus.o_ready      = ready_q;
  assign bus.o_relock_cnt = relock_q;

endmodule

// File: tb/tb_clock_gen_rst_seq.sv
// Directed bench for clock_gen_rst_seq: main instance with a short lock timeout,
// plus a single-stage instance for the NUM_RST=1 / minimum-parameter corner.
module tb_clock_gen_rst_seq;

  logic clk;
  logic rst0;
  logic rst1;
  int   tests_run;
  int   tests_failed;

  clock_gen_rst_seq_if #(.NUM_RST(3)) bus0 ();
  clock_gen_rst_seq_if #(.NUM_RST(1)) bus1 ();

  clock_gen_rst_seq #(
    .HOLD_CYCLES(16), .NUM_RST(3), .STAGE_GAP(4), .AR_PULSE(8), .LOCK_TIMEOUT(100)
  ) dut0 (
    .i_clk(clk), .i_rst(rst0), .bus(bus0)
  );

  clock_gen_rst_seq #(
    .HOLD_CYCLES(1), .NUM_RST(1), .STAGE_GAP(1), .AR_PULSE(1), .LOCK_TIMEOUT(65536)
  ) dut1 (
    .i_clk(clk), .i_rst(rst1), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge after the last reset edge; the next tick is edge 0.
  task automatic start_from_reset(input logic lock_val);
    rst0 = 1'b1;
    bus0.i_locked = lock_val;
    tick;
    tick;
    rst0 = 1'b0;
  endtask

  function automatic logic [2:0] staged(input int e, input int base);
    if (e < base)          return 3'b111;
    else if (e < base + 4) return 3'b110;
    else if (e < base + 8) return 3'b100;
    else                   return 3'b000;
  endfunction

  task automatic test_reset;
    start_from_reset(1'b1);
    tests_run++;
    if (bus0.o_pll_areset !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_areset: got %b want 1", bus0.o_pll_areset);
    end
    tests_run++;
    if (bus0.o_rst !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL reset_rst: got %b want 111", bus0.o_rst);
    end
    tests_run++;
    if (bus0.o_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b want 0", bus0.o_ready);
    end
    tests_run++;
    if (bus0.o_relock_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_relock: got %0d want 0", bus0.o_relock_cnt);
    end
  endtask

  task automatic test_bring_up;
    logic [2:0] exp_rst;
    start_from_reset(1'b0);
    for (int e = 0; e <= 50; e++) begin
      bus0.i_locked = (e >= 20);
      tick;
      exp_rst = staged(e, 38);
      tests_run++;
      if (bus0.o_pll_areset !== (e < 8)) begin
        tests_failed++;
        $display("[TB] FAIL bringup_areset e=%0d: got %b want %b", e, bus0.o_pll_areset, (e < 8));
      end
      tests_run++;
      if (bus0.o_rst !== exp_rst) begin
        tests_failed++;
        $display("[TB] FAIL bringup_rst e=%0d: got %b want %b", e, bus0.o_rst, exp_rst);
      end
      tests_run++;
      if (bus0.o_ready !== (e >= 46)) begin
        tests_failed++;
        $display("[TB] FAIL bringup_ready e=%0d: got %b want %b", e, bus0.o_ready, (e >= 46));
      end
    end
    tests_run++;
    if (bus0.o_relock_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL bringup_relock: got %0d want 0", bus0.o_relock_cnt);
    end
  endtask

  task automatic test_hold_glitch;
    logic [2:0] exp_rst;
    start_from_reset(1'b0);
    for (int e = 0; e <= 56; e++) begin
      bus0.i_locked = (e >= 20) && !(e >= 26 && e <= 28);
      tick;
      exp_rst = staged(e, 47);
      tests_run++;
      if (bus0.o_rst !== exp_rst) begin
        tests_failed++;
        $display("[TB] FAIL glitch_rst e=%0d: got %b want %b", e, bus0.o_rst, exp_rst);
      end
      tests_run++;
      if (bus0.o_ready !== (e >= 55)) begin
        tests_failed++;
        $display("[TB] FAIL glitch_ready e=%0d: got %b want %b", e, bus0.o_ready, (e >= 55));
      end
    end
    tests_run++;
    if (bus0.o_relock_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_relock: got %0d want 0", bus0.o_relock_cnt);
    end
  endtask

  task automatic test_loss_in_run;
    logic [2:0] exp_rst;
    logic [7:0] exp_cnt;
    start_from_reset(1'b0);
    for (int e = 0; e <= 100; e++) begin
      bus0.i_locked = (e >= 20) && !(e >= 60 && e < 70);
      tick;
      exp_rst = (e < 62) ? staged(e, 38) : staged(e, 88);
      exp_cnt = (e >= 62) ? 8'd1 : 8'd0;
      tests_run++;
      if (bus0.o_rst !== exp_rst) begin
        tests_failed++;
        $display("[TB] FAIL loss_rst e=%0d: got %b want %b", e, bus0.o_rst, exp_rst);
      end
      tests_run++;
      if (bus0.o_ready !== (exp_rst == 3'b000)) begin
        tests_failed++;
        $display("[TB] FAIL loss_ready e=%0d: got %b want %b", e, bus0.o_ready, (exp_rst == 3'b000));
      end
      tests_run++;
      if (bus0.o_relock_cnt !== exp_cnt) begin
        tests_failed++;
        $display("[TB] FAIL loss_relock e=%0d: got %0d want %0d", e, bus0.o_relock_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_timeout;
    logic exp_ar;
    start_from_reset(1'b0);
    for (int e = 0; e <= 330; e++) begin
      tick;
      exp_ar = (e < 8) || ((e >= 108) && (((e - 108) % 108) < 8));
      tests_run++;
      if (bus0.o_pll_areset !== exp_ar) begin
        tests_failed++;
        $display("[TB] FAIL timeout_areset e=%0d: got %b want %b", e, bus0.o_pll_areset, exp_ar);
      end
      tests_run++;
      if (bus0.o_rst !== 3'b111) begin
        tests_failed++;
        $display("[TB] FAIL timeout_rst e=%0d: got %b want 111", e, bus0.o_rst);
      end
    end
  endtask

  task automatic test_reset_mid_release;
    logic [2:0] exp_rst;
    start_from_reset(1'b0);
    for (int e = 0; e <= 80; e++) begin
      rst0 = (e == 39);
      bus0.i_locked = (e >= 20);
      tick;
      if (e == 38) begin
        tests_run++;
        if (bus0.o_rst !== 3'b110) begin
          tests_failed++;
          $display("[TB] FAIL midrst_first e=%0d: got %b want 110", e, bus0.o_rst);
        end
      end else if (e == 39) begin
        tests_run++;
        if (bus0.o_rst !== 3'b111 || bus0.o_pll_areset !== 1'b1 ||
            bus0.o_relock_cnt !== 8'd0 || bus0.o_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL midrst_reset: got rst=%b ar=%b cnt=%0d rdy=%b want rst=111 ar=1 cnt=0 rdy=0",
                   bus0.o_rst, bus0.o_pll_areset, bus0.o_relock_cnt, bus0.o_ready);
        end
      end else if (e >= 40) begin
        exp_rst = staged(e, 65);
        tests_run++;
        if (bus0.o_pll_areset !== (e < 48)) begin
          tests_failed++;
          $display("[TB] FAIL midrst_areset e=%0d: got %b want %b", e, bus0.o_pll_areset, (e < 48));
        end
        tests_run++;
        if (bus0.o_rst !== exp_rst) begin
          tests_failed++;
          $display("[TB] FAIL midrst_rst e=%0d: got %b want %b", e, bus0.o_rst, exp_rst);
        end
        tests_run++;
        if (bus0.o_ready !== (e >= 73)) begin
          tests_failed++;
          $display("[TB] FAIL midrst_ready e=%0d: got %b want %b", e, bus0.o_ready, (e >= 73));
        end
      end
    end
    rst0 = 1'b0;
  endtask

  task automatic test_saturation;
    int waited;
    bit stuck;
    stuck = 1'b0;
    start_from_reset(1'b1);
    for (int i = 0; i < 260 && !stuck; i++) begin
      waited = 0;
      while (bus0.o_ready !== 1'b1 && waited < 200) begin
        tick;
        waited++;
      end
      if (bus0.o_ready !== 1'b1) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL sat_ready_wait loss=%0d: got ready=%b want 1 within 200 cycles", i, bus0.o_ready);
        stuck = 1'b1;
      end else begin
        bus0.i_locked = 1'b0;
        tick;
        tick;
        tick;
        bus0.i_locked = 1'b1;
        if (i == 0 || i == 254) begin
          tests_run++;
          if (bus0.o_relock_cnt !== ((i == 0) ? 8'd1 : 8'd255)) begin
            tests_failed++;
            $display("[TB] FAIL sat_count loss=%0d: got %0d want %0d", i, bus0.o_relock_cnt,
                     (i == 0) ? 1 : 255);
          end
        end
      end
    end
    tick;
    tests_run++;
    if (bus0.o_relock_cnt !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold: got %0d want 255", bus0.o_relock_cnt);
    end
    rst0 = 1'b1;
    tick;
    rst0 = 1'b0;
    tests_run++;
    if (bus0.o_relock_cnt !== 8'd0 || bus0.o_rst !== 3'b111 || bus0.o_pll_areset !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sat_clear: got cnt=%0d rst=%b ar=%b want cnt=0 rst=111 ar=1",
               bus0.o_relock_cnt, bus0.o_rst, bus0.o_pll_areset);
    end
  endtask

  task automatic test_single_stage;
    rst1 = 1'b1;
    bus1.i_locked = 1'b1;
    tick;
    tick;
    rst1 = 1'b0;
    for (int e = 0; e <= 13; e++) begin
      bus1.i_locked = (e < 10);
      tick;
      tests_run++;
      if (bus1.o_pll_areset !== (e < 1)) begin
        tests_failed++;
        $display("[TB] FAIL single_areset e=%0d: got %b want %b", e, bus1.o_pll_areset, (e < 1));
      end
      tests_run++;
      if (bus1.o_rst[0] !== !(e >= 3 && e < 12)) begin
        tests_failed++;
        $display("[TB] FAIL single_rst e=%0d: got %b want %b", e, bus1.o_rst[0], !(e >= 3 && e < 12));
      end
      tests_run++;
      if (bus1.o_ready !== (e >= 3 && e < 12)) begin
        tests_failed++;
        $display("[TB] FAIL single_ready e=%0d: got %b want %b", e, bus1.o_ready, (e >= 3 && e < 12));
      end
    end
    tests_run++;
    if (bus1.o_relock_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL single_relock: got %0d want 1", bus1.o_relock_cnt);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst0          = 1'b1;
    rst1          = 1'b1;
    bus0.i_locked = 1'b0;
    bus1.i_locked = 1'b0;

    test_reset();
    test_bring_up();
    test_hold_glitch();
    test_loss_in_run();
    test_timeout();
    test_reset_mid_release();
    test_saturation();
    test_single_stage();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
